// File: rtl/apb_exe_regs.sv
// apb_exe_regs: APB3 register front-end that holds operands for the shift exe unit and captures its result.
// Optional feature macro: APB_SLVERR_EN (pslverr on unmapped or illegal accesses; tied 0 when undefined).
module apb_exe_regs #(
  parameter int N       = 8,
  parameter int EXE_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [7:0]    paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [N-1:0]  exe_a,
  output logic [N-1:0]  exe_b,
  input  logic [N-1:0]  exe_result,
  input  logic          exe_error,
  output logic          done
);
  localparam logic [5:0] ADDR_A      = 6'h00;
  localparam logic [5:0] ADDR_B      = 6'h01;
  localparam logic [5:0] ADDR_CTRL   = 6'h02;
  localparam logic [5:0] ADDR_STATUS = 6'h03;
  localparam logic [5:0] ADDR_RESULT = 6'h04;
  localparam logic [3:0] LAT         = 4'(EXE_LAT);

  // S_IDLE: waiting for start | S_EXEC: counting down the settle latency
  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0] r_a, r_b, r_result;
  logic         r_done, r_error;

  logic [5:0]   w_word;
  logic         w_busy, w_access, w_wr, w_mapped, w_wr_illegal, w_wr_ok;
  logic         w_start, w_clear, w_start_acc, w_clear_acc, w_capture;
  logic         w_unused;

  assign w_word   = paddr[7:2];
  assign w_busy   = (r_state == S_EXEC);
  assign w_access = psel & penable;
  assign w_wr     = w_access & pwrite;
  assign w_mapped = (w_word <= ADDR_RESULT);
  assign w_unused = ^{paddr[1:0], pwdata[31:N]};

  always_comb begin
    w_wr_illegal = 1'b1;
    case (w_word)
      ADDR_A, ADDR_B: w_wr_illegal = w_busy;
      ADDR_CTRL:      w_wr_illegal = w_busy & pwdata[0];
      default:        w_wr_illegal = 1'b1;
    endcase
  end

  // Illegal writes are dropped whether or not they are reported on pslverr.
  assign w_wr_ok = w_wr & ~w_wr_illegal;
  assign w_start = w_wr_ok & (w_word == ADDR_CTRL) & pwdata[0];
  assign w_clear = w_wr_ok & (w_word == ADDR_CTRL) & pwdata[1];

`ifdef APB_SLVERR_EN
  assign pslverr = w_access & (~w_mapped | (pwrite & w_wr_illegal));
`else
  assign pslverr = 1'b0;
`endif

  assign pready = 1'b1;
  assign exe_a  = r_a;
  assign exe_b  = r_b;
  assign done   = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_acc = 1'b0;
    w_clear_acc = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear_acc = w_clear;
        if (w_start) begin
          w_start_acc = 1'b1;
          w_cnt_nxt   = LAT;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_ok && (w_word == ADDR_A)) r_a <= pwdata[N-1:0];
      if (w_wr_ok && (w_word == ADDR_B)) r_b <= pwdata[N-1:0];
      if (w_clear_acc) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_start_acc) r_done <= 1'b0;
      if (w_capture) begin
        r_result <= exe_result;
        r_error  <= exe_error;
        r_done   <= 1'b1;
      end
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite) begin
      case (w_word)
        ADDR_A:      prdata = 32'($signed(r_a));
        ADDR_B:      prdata = 32'($signed(r_b));
        ADDR_STATUS: prdata = {29'd0, r_error, r_done, w_busy};
        ADDR_RESULT: prdata = 32'($signed(r_result));
        default:     prdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_exe_regs.sv
// tb_apb_exe_regs: directed vector table, hand-written timing sequences and a randomized run
// against an operation-level reference model of apb_exe_regs.
`timescale 1ns/1ps
module tb_apb_exe_regs;
  localparam int N   = 8;
  localparam int LAT = 4;
`ifdef APB_SLVERR_EN
  localparam logic SLV = 1'b1;
`else
  localparam logic SLV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [N-1:0] exe_a, exe_b, exe_result;
  logic        exe_error, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  apb_exe_regs #(.N(N), .EXE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .exe_a(exe_a), .exe_b(exe_b), .exe_result(exe_result), .exe_error(exe_error), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational shift unit: A shifted left by B[2:0]; error when B is outside 0..7.
  always_comb begin
    exe_result = exe_a << exe_b[2:0];
    exe_error  = (int'(exe_b) >= N);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts and ends at a falling edge; e is the cycle count after the committing edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata; err = pslverr; e = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err; int e;
    xfer(1'b1, addr, wd, rd, err, e);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err; int e;
    xfer(1'b0, addr, 32'd0, rd, err, e);
    chk(name, rd, exp);
  endtask

  task automatic wr_chk_err(input string name, input logic [7:0] addr, input logic [31:0] wd,
                            input logic exp_err);
    logic [31:0] rd; logic err; int e;
    xfer(1'b1, addr, wd, rd, err, e);
    chk(name, 32'(err), 32'(exp_err));
  endtask

  // ---------------- reference model (operation level, timestamped by clock edge) -------------
  logic [7:0] m_a, m_b, m_result;
  logic       m_done, m_error, m_busy;
  int         m_cap;

  function automatic logic [31:0] sx(input logic [7:0] v);
    int s;
    s = (v >= 8'd128) ? int'(v) - 256 : int'(v);
    return 32'(s);
  endfunction

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [7:0] b);
    int prod;
    prod = int'(a) * (2 ** (int'(b) % 8));
    return prod[7:0];
  endfunction

  task automatic m_capture();
    m_result = ref_shift(m_a, m_b);
    m_error  = (int'(m_b) > 7);
    m_done   = 1'b1;
    m_busy   = 1'b0;
  endtask

  task automatic m_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int e, output logic [31:0] exp_rd, output logic exp_err);
    int w;
    logic bad;
    w = int'(addr[7:2]);
    if (m_busy && m_cap < e) m_capture();
    exp_rd = 32'd0;
    bad    = 1'b0;
    if (!wr) begin
      case (w)
        0: exp_rd = sx(m_a);
        1: exp_rd = sx(m_b);
        3: exp_rd = {29'd0, m_error, m_done, m_busy};
        4: exp_rd = sx(m_result);
        default: exp_rd = 32'd0;
      endcase
      bad = (w > 4);
    end else begin
      case (w)
        0: if (m_busy) bad = 1'b1; else m_a = wd[7:0];
        1: if (m_busy) bad = 1'b1; else m_b = wd[7:0];
        2: begin
          if (wd[0] && m_busy) bad = 1'b1;
          else if (!m_busy) begin
            if (wd[1]) begin m_done = 1'b0; m_error = 1'b0; end
            if (wd[0]) begin m_done = 1'b0; m_busy = 1'b1; m_cap = e + LAT; end
          end
        end
        default: bad = 1'b1;
      endcase
    end
    exp_err = bad & SLV;
    if (m_busy && m_cap <= e) m_capture();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          gap;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                              input int gap, input logic [31:0] exp_rd, input logic exp_err,
                              input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.gap = gap;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int e;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pwdata = 32'd0;
    idle_cyc(3);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exe_a", 32'(exe_a), 32'd0);
    chk("rst_pready", 32'(pready), 32'd1);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    rst = 1'b0;
    idle_cyc(1);
    rd_chk("rst_rd_a", 8'h00, 32'd0);
    rd_chk("rst_rd_b", 8'h04, 32'd0);
    rd_chk("rst_rd_status", 8'h0C, 32'd0);
    rd_chk("rst_rd_result", 8'h10, 32'd0);

    vq.push_back(mk(1, 8'h00, 32'h1A, 0, 32'h0,        0,   "wr_a_1a"));
    vq.push_back(mk(1, 8'h04, 32'h02, 0, 32'h0,        0,   "wr_b_2"));
    vq.push_back(mk(1, 8'h08, 32'h01, 0, 32'h0,        0,   "start_1"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  0, 32'h1,        0,   "status_busy"));
    vq.push_back(mk(0, 8'h10, 32'h0,  2, 32'h68,       0,   "result_basic"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  0, 32'h2,        0,   "status_done"));
    vq.push_back(mk(0, 8'h00, 32'h0,  0, 32'h1A,       0,   "rd_a_pos"));
    vq.push_back(mk(0, 8'h04, 32'h0,  0, 32'h02,       0,   "rd_b_pos"));
    vq.push_back(mk(1, 8'h00, 32'hE6, 0, 32'h0,        0,   "wr_a_neg"));
    vq.push_back(mk(1, 8'h08, 32'h01, 0, 32'h0,        0,   "start_2"));
    vq.push_back(mk(0, 8'h10, 32'h0,  3, 32'hFFFFFF98, 0,   "result_neg"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  0, 32'h2,        0,   "status_neg"));
    vq.push_back(mk(0, 8'h00, 32'h0,  0, 32'hFFFFFFE6, 0,   "rd_a_sext"));
    vq.push_back(mk(1, 8'h04, 32'hFD, 0, 32'h0,        0,   "wr_b_neg"));
    vq.push_back(mk(1, 8'h08, 32'h01, 0, 32'h0,        0,   "start_3"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  3, 32'h6,        0,   "status_error"));
    vq.push_back(mk(0, 8'h04, 32'h0,  0, 32'hFFFFFFFD, 0,   "rd_b_sext"));
    vq.push_back(mk(1, 8'h08, 32'h02, 0, 32'h0,        0,   "clear_done"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  0, 32'h0,        0,   "status_cleared"));
    vq.push_back(mk(0, 8'h10, 32'h0,  0, 32'hFFFFFFC0, 0,   "result_kept"));
    vq.push_back(mk(0, 8'h08, 32'h0,  0, 32'h0,        0,   "rd_ctrl_zero"));
    vq.push_back(mk(0, 8'h14, 32'h0,  0, 32'h0,        SLV, "rd_unmapped"));
    vq.push_back(mk(0, 8'h03, 32'h0,  0, 32'hFFFFFFE6, 0,   "rd_a_lowbits"));
    vq.push_back(mk(1, 8'h0C, 32'hFF, 0, 32'h0,        SLV, "wr_status_ro"));
    vq.push_back(mk(0, 8'h0C, 32'h0,  0, 32'h0,        0,   "status_after_ro"));

    foreach (vq[i]) begin
      idle_cyc(vq[i].gap);
      xfer(vq[i].wr, vq[i].addr, vq[i].wd, rd, err, e);
      chk($sformatf("%s/rdata", vq[i].name), rd, vq[i].exp_rd);
      chk($sformatf("%s/slverr", vq[i].name), 32'(err), 32'(vq[i].exp_err));
    end

    // Capture boundary: read ending at T+LAT sees busy, the next read sees done.
    wr_reg(8'h00, 32'h03);
    wr_reg(8'h04, 32'h01);
    wr_reg(8'h08, 32'h01);
    idle_cyc(LAT - 2);
    rd_chk("edge_status_busy", 8'h0C, 32'h1);
    rd_chk("edge_status_done", 8'h0C, 32'h2);

    // done rises exactly LAT edges after start; a start on the next edge is accepted.
    wr_reg(8'h08, 32'h01);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk($sformatf("lat_done_low_%0d", k), 32'(done), 32'd0);
    end
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_done_high", 32'(done), 32'd1);
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("b2b_done_cleared", 32'(done), 32'd0);
    rd_chk("b2b_status_busy", 8'h0C, 32'h1);
    idle_cyc(LAT);
    rd_chk("b2b_status_done", 8'h0C, 32'h2);
    rd_chk("b2b_result", 8'h10, 32'h06);

    // Busy protection: second start and operand write are dropped.
    wr_reg(8'h00, 32'h11);
    wr_reg(8'h08, 32'h01);
    wr_chk_err("busy_start_err", 8'h08, 32'h01, SLV);
    wr_chk_err("busy_wr_a_err", 8'h00, 32'h55, SLV);
    chk("busy_exe_a", 32'(exe_a), 32'h11);
    rd_chk("busy_status_after", 8'h0C, 32'h2);
    rd_chk("busy_result", 8'h10, 32'h22);
    rd_chk("busy_rd_a", 8'h00, 32'h11);

    // Start and clear_done together: start wins.
    wr_reg(8'h08, 32'h03);
    rd_chk("both_status_busy", 8'h0C, 32'h1);
    idle_cyc(LAT);
    rd_chk("both_status_done", 8'h0C, 32'h2);

    // Asynchronous reset mid-cycle clears everything at once.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    #1;
    chk("prerst_prdata", prdata, 32'h22);
    #2 rst = 1'b1;
    #1;
    chk("arst_prdata_result", prdata, 32'd0);
    chk("arst_exe_a", 32'(exe_a), 32'd0);
    chk("arst_exe_b", 32'(exe_b), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    paddr = 8'h00;
    #1;
    chk("arst_prdata_a", prdata, 32'd0);
    psel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_cyc(1);

    // Reset during EXEC abandons the operation.
    wr_reg(8'h00, 32'h05);
    wr_reg(8'h04, 32'h01);
    wr_reg(8'h08, 32'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midexec_done", 32'(done), 32'd0);
    chk("midexec_exe_a", 32'(exe_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cyc(LAT + 2);
    chk("midexec_done_after", 32'(done), 32'd0);
    rd_chk("midexec_status", 8'h0C, 32'd0);
    rd_chk("midexec_result", 8'h10, 32'd0);

    // Randomized run against the reference model (DUT is in its reset state here).
    m_a = 8'd0; m_b = 8'd0; m_result = 8'd0;
    m_done = 1'b0; m_error = 1'b0; m_busy = 1'b0; m_cap = 0;
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic wr;
      logic [7:0] addr;
      logic [31:0] wd;
      kind = int'($urandom_range(0, 9));
      wr = 1'b1;
      addr = 8'h00;
      wd = $urandom;
      if (kind == 9) begin
        idle_cyc(int'($urandom_range(1, LAT + 1)));
        continue;
      end
      case (kind)
        0, 1: addr = {6'h00, 2'($urandom_range(0, 3))};
        2: begin
          addr = 8'h04;
          wd = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 9)) : $urandom;
        end
        3, 4: begin
          addr = 8'h08;
          wd = {$urandom_range(0, 1) == 1 ? 30'h2AAAAAAA : 30'd0, 2'($urandom_range(0, 2))};
        end
        5, 6, 7: begin
          wr = 1'b0;
          addr = 8'($urandom_range(0, 31));
        end
        default: begin
          addr = 8'($urandom_range(0, 31));
          if (addr[7:2] == 6'h02) wd[1:0] = 2'($urandom_range(0, 2));
        end
      endcase
      xfer(wr, addr, wd, rd, err, e);
      m_xfer(wr, addr, wd, e, exp_rd, exp_err);
      chk($sformatf("rnd%0d_rdata@%h", i, addr), rd, exp_rd);
      chk($sformatf("rnd%0d_slverr@%h", i, addr), 32'(err), 32'(exp_err));
      chk($sformatf("rnd%0d_done", i), 32'(done), 32'(m_done));
      chk($sformatf("rnd%0d_exe_a", i), 32'(exe_a), 32'(m_a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_exe_regs.md
# apb_exe_regs

APB3 slave front-end that sits directly upstream of the shift execution unit in `exe_unit_1`. It latches signed operands A and B written over the bus and drives them onto the unit's inputs. On a start command it waits a fixed settle latency, then captures the unit's `result` and `error` into read-only registers. Software polls STATUS or watches `done`.

## Interface
Parameters:
- `N`, 8: operand/result width; the exe unit is instantiated with the same N.
- `EXE_LAT`, 1: settle cycles between start and result capture; legal range 1..15.

Ports:
- `clk`  in  1  system clock (doubles as APB PCLK); all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  8  byte address; bits [1:0] ignored.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  transfer error.
- `exe_a`  out  N  operand A to exe unit (`A`).
- `exe_b`  out  N  operand B to exe unit (`B`).
- `exe_result`  in  N  exe unit `result`.
- `exe_error`  in  1  exe unit `error`.
- `done`  out  1  level; result valid and not yet cleared.

## Operation
- Register map:
  - 0x00 A (RW, N bits).
  - 0x04 B (RW, N bits).
  - 0x08 CTRL (WO; bit0 start, bit1 clear_done; reads 0).
  - 0x0C STATUS (RO; bit0 busy, bit1 done, bit2 error).
  - 0x10 RESULT (RO, N bits).
- Writes take `pwdata[N-1:0]`.
- Reads of A, B and RESULT are sign-extended from bit N-1 to 32 bits.
- Unmapped reads return 0.
- `exe_a` and `exe_b` are driven directly from the A and B registers, so they are stable for the whole operation.
- FSM states:
  - IDLE: start write → EXEC. Counter loads EXE_LAT, done clears, busy sets.
  - EXEC: counter decrements each edge. On the edge where the counter is 1:
    - `exe_result` → RESULT and `exe_error` → STATUS.error.
    - done = 1, busy = 0, → IDLE.
- The exe unit is combinational; no other states exist.
- Start written while busy is ignored.
- Writes to A or B while busy are ignored, so operands cannot change mid-operation.
- clear_done in IDLE clears done and STATUS.error. RESULT is retained.
- Start and clear_done written in the same transfer: start wins, and done ends up 0.
- STATUS.error reflects the last captured operation only.
- `rst` asserted at any time, including mid-EXEC: state → IDLE, counter 0, operation abandoned.

## Timing
- Reset values:
  - A, B, RESULT, counter = 0.
  - busy, done, error = 0.
  - `prdata` = 0, `pready` = 1, `pslverr` = 0.
  - `exe_a` and `exe_b` = 0.
- APB: zero wait states.
  - `pready` is held at 1.
  - A write commits at the edge where psel & penable & pwrite.
  - `prdata` is a combinational mux of `paddr`, gated by psel & !pwrite, and is 0 otherwise.
- Start accepted at edge T:
  - busy = 1 after T.
  - RESULT, error and done are updated after edge T+EXE_LAT.
  - A STATUS read in the access phase ending at T+EXE_LAT sees busy = 1. The next read sees done = 1.
- Back-to-back: a new start can be accepted at the edge immediately after capture.

## Configuration
- `APB_SLVERR_EN` defined:
  - `pslverr` = 1 during the access phase for unmapped addresses.
  - `pslverr` = 1 for writes to STATUS or RESULT.
  - `pslverr` = 1 for writes to A, B or CTRL.start while busy.
  - The erroneous write has no effect.
- Undefined: `pslverr` is tied 0. The same writes are silently ignored.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all registers, `done`, `exe_a`/`exe_b` and `prdata` read 0 immediately.
- Basic shift: write A = 0x1A, B = 2, start → after EXE_LAT cycles, done = 1, RESULT reads 0x00000068, STATUS = 0b010.
- Negative operand: A = 0xE6 (−26), B = 2, start → RESULT reads 0xFFFFFF98, error = 0.
- Error path: A = 0xE6, B = 0xFD (−3), start → STATUS = 0b110. clear_done → STATUS = 0b000, RESULT still holds the captured value.
- Busy protection (EXE_LAT = 4, macro on): start, then write A = 0x55 at T+1 → `pslverr` = 1, `exe_a` unchanged, and a second start is ignored. Macro off: same, with `pslverr` = 0.
- Reset mid-EXEC (EXE_LAT = 4): start, assert `rst` at T+2 → busy = 0, done = 0, RESULT = 0. No capture occurs after `rst` releases.
